// File: rtl/dm_pkg.sv
// Shared access-type codes, FSM state encoding and store lane helpers for dm_pipe.
package dm_pkg;

  localparam logic [2:0] DM_BYTE              = 3'b000;
  localparam logic [2:0] DM_HALFWORD          = 3'b001;
  localparam logic [2:0] DM_WORD              = 3'b010;
  localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;
  localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dm_state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} dm_size_e;

  // Unknown type codes collapse to a full word access.
  function automatic dm_size_e dm_size(input logic [2:0] t);
    case (t)
      DM_BYTE, DM_BYTE_UNSIGNED:         return SZ_BYTE;
      DM_HALFWORD, DM_HALFWORD_UNSIGNED: return SZ_HALF;
      default:                           return SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] dm_wstrb(input logic [2:0] t, input logic [1:0] off);
    case (dm_size(t))
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] dm_wdata(input logic [2:0] t, input logic [31:0] d);
    case (dm_size(t))
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/dm_load_align.sv
// Load lane select plus sign/zero extension of the sampled memory word.
module dm_load_align
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  ld_type,
  input  logic [1:0]  offset,
  output logic [31:0] value
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];
    value  = word;
    case (dm_size(ld_type))
      SZ_BYTE: value = ld_type[2] ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: value = ld_type[2] ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: value = word;
    endcase
  end

endmodule

// File: rtl/dm_pipe.sv
// Handshaked MEM-stage data memory with programmable wait states.
// Build option DM_FAULT_CHECK_EN: trap misaligned / out-of-range accesses on rsp_err.
//
// state | meaning
// IDLE  | ready for a request; stores commit on the accept edge
// WAIT  | down-counter burning the configured wait states
// RESP  | response registered next edge, held until rsp_ready
module dm_pipe
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  dm_state_e          state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               init_q;
  logic               accept, enter_resp, req_fault;
  logic [ADDR_W-1:0]  req_idx, idx_q, rd_idx;
  logic               we_q, fault_q, valid_q;
  logic [2:0]         type_q;
  logic [1:0]         off_q;
  logic [31:0]        rd_word_q, rdata_q, load_val;
  logic [3:0]         wstrb;
  logic [31:0]        wdata_rep;
  logic [31:0]        mem_q [DEPTH_WORDS] = '{default: 32'h0};

  assign req_idx   = req_addr[ADDR_W+1:2];
  assign req_ready = init_q && (state_q == IDLE);
  assign accept    = req_valid && req_ready;
  assign rd_idx    = (state_q == IDLE) ? req_idx : idx_q;
  assign wstrb     = dm_wstrb(req_type, req_addr[1:0]);
  assign wdata_rep = dm_wdata(req_type, req_wdata);

`ifdef DM_FAULT_CHECK_EN
  always_comb begin
    req_fault = (req_addr[31:ADDR_W+2] != '0);
    case (dm_size(req_type))
      SZ_HALF: if (req_addr[0])          req_fault = 1'b1;
      SZ_WORD: if (req_addr[1:0] != 2'b00) req_fault = 1'b1;
      default: ;
    endcase
  end
`else
  logic unused_addr_hi;
  assign req_fault      = 1'b0;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (WAIT_CYCLES == 0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT: if (cnt_q == 3'd0) begin
        state_d    = RESP;
        enter_resp = 1'b1;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
      RESP: if (valid_q && rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      init_q  <= 1'b0;
      we_q    <= 1'b0;
      type_q  <= DM_WORD;
      off_q   <= 2'b00;
      idx_q   <= '0;
      fault_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      init_q  <= 1'b1;
      if (accept) begin
        we_q    <= req_we;
        type_q  <= req_type;
        off_q   <= req_addr[1:0];
        idx_q   <= req_idx;
        fault_q <= req_fault;
      end
      // Response registers load one edge after RESP is entered.
      if (state_q == RESP && !valid_q) begin
        valid_q <= 1'b1;
        rdata_q <= (we_q || fault_q) ? 32'h0 : load_val;
      end else if (valid_q && rsp_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Array has no reset: a committed store survives a mid-operation reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[req_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
    if (enter_resp) rd_word_q <= mem_q[rd_idx];
  end

  dm_load_align u_align (
    .word    (rd_word_q),
    .ld_type (type_q),
    .offset  (off_q),
    .value   (load_val)
  );

`ifdef DM_FAULT_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else if (state_q == RESP && !valid_q) err_q <= fault_q;
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dm_pipe.sv
// Bench for dm_pipe: two instances (0 and 3 wait states), directed table plus random vs byte-array model.
module tb_dm_pipe;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        rstn      [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_type  [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int total = 0;
  int bad   = 0;
  logic [7:0] mb [2][512];

  always #5 clk = ~clk;

  dm_pipe #(.DEPTH_WORDS(128), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rstn(rstn[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_type(req_type[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dm_pipe #(.DEPTH_WORDS(128), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rstn(rstn[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_type(req_type[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] t);
    if (t == 3'b000 || t == 3'b100) return 1;
    if (t == 3'b001 || t == 3'b101) return 2;
    return 4;
  endfunction

  // Memory seen as 512 little-endian bytes; sub-word accesses round the address down to their size.
  task automatic model(input int d, input logic we, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] er, output logic ee);
    int n;
    int base;
    logic [31:0] v;
    n  = size_of(t);
    er = 32'h0;
    ee = 1'b0;
`ifdef DM_FAULT_CHECK_EN
    if (a >= 32'd512 || (a % n) != 0) ee = 1'b1;
`endif
    base = int'((a % 32'd512) / n * n);
    if (ee) return;
    if (we) begin
      for (int i = 0; i < n; i++) mb[d][base+i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(mb[d][base+i]) << (8*i));
      if (n < 4 && t[2] == 1'b0 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      er = v;
    end
  endtask

  // Full request/response transaction; checks latency, ready and hold stability; returns DUT and model results.
  task automatic access(input int d, input logic we, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, input string tag,
                        output logic [31:0] rd, output logic er,
                        output logic [31:0] mrd, output logic mer);
    int n;
    int lat;
    logic rdy_bad;
    logic hold_bad;
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_type[d]  = t;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    rd = 32'h0; er = 1'b0; mrd = 32'h0; mer = 1'b0;
    if (!req_ready[d]) begin
      chk({tag, "_ready_timeout"}, 32'(req_ready[d]), 32'h1);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    req_we[d]    = 1'($urandom);
    model(d, we, t, a, wd, mrd, mer);
    lat = 0;
    rdy_bad = 1'b0;
    while (!rsp_valid[d] && lat < 40) begin
      if (req_ready[d]) rdy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), (d == 0) ? 32'd1 : 32'd4);
    rd = rsp_rdata[d];
    er = rsp_err[d];
    hold_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (req_ready[d] || !rsp_valid[d] || rsp_rdata[d] !== rd || rsp_err[d] !== er) hold_bad = 1'b1;
    end
    if (req_ready[d]) rdy_bad = 1'b1;
    chk({tag, "_ready_low"}, 32'(rdy_bad), 32'h0);
    if (hold > 0) chk({tag, "_hold"}, 32'(hold_bad), 32'h0);
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    chk({tag, "_after_hs"}, {30'h0, rsp_valid[d], req_ready[d]}, 32'h1);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  t;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  vec_t tab[$];

  function automatic void add(input logic we, input logic [2:0] t, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = we; v.t = t; v.a = a; v.wd = wd; v.er = er; v.ee = ee;
    tab.push_back(v);
  endfunction

  initial begin
    logic [31:0] rd, mrd;
    logic er, mer;
    logic we;
    logic [2:0] t;
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_type[d] = 3'b0;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
      for (int i = 0; i < 512; i++) mb[d][i] = 8'h0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      chk($sformatf("reset_outs%0d", d), {rsp_rdata[d][29:0], req_ready[d], rsp_valid[d]} | 32'(rsp_err[d]), 32'h0);
    @(negedge clk);
    rstn[0] = 1'b1; rstn[1] = 1'b1;
    #1;
    chk("ready_before_edge", {31'h0, req_ready[0] | req_ready[1]}, 32'h0);
    @(posedge clk); #1;
    chk("ready_after_edge", {30'h0, req_ready[0], req_ready[1]}, 32'h3);

    add(1, DM_WORD,              32'h10, 32'h1234_5678, 32'h0, 0);
    add(0, DM_BYTE,              32'h13, 32'h0,         32'h0000_0012, 0);
    add(0, DM_BYTE_UNSIGNED,     32'h10, 32'h0,         32'h0000_0078, 0);
    add(1, DM_BYTE,              32'h21, 32'h0000_00F0, 32'h0, 0);
    add(0, DM_BYTE,              32'h21, 32'h0,         32'hFFFF_FFF0, 0);
    add(0, DM_HALFWORD,          32'h20, 32'h0,         32'hFFFF_F000, 0);
    add(0, DM_HALFWORD_UNSIGNED, 32'h20, 32'h0,         32'h0000_F000, 0);
    add(0, DM_HALFWORD,          32'h12, 32'h0,         32'h0000_1234, 0);
    add(0, 3'b111,               32'h10, 32'h0,         32'h1234_5678, 0);
    add(1, DM_HALFWORD_UNSIGNED, 32'h32, 32'h5555_8001, 32'h0, 0);
    add(0, DM_HALFWORD,          32'h32, 32'h0,         32'hFFFF_8001, 0);
    add(1, DM_WORD,              32'h00, 32'h0000_0055, 32'h0, 0);
`ifdef DM_FAULT_CHECK_EN
    add(0, DM_WORD,              32'h202, 32'h0,         32'h0, 1);
    add(1, DM_WORD,              32'h42,  32'hDEAD_BEEF, 32'h0, 1);
    add(0, DM_WORD,              32'h40,  32'h0,         32'h0, 0);
    add(0, DM_WORD,              32'h200, 32'h0,         32'h0, 1);
    add(0, DM_HALFWORD,          32'h13,  32'h0,         32'h0, 1);
`else
    add(0, DM_WORD,              32'h202, 32'h0,         32'h0000_0055, 0);
    add(1, DM_WORD,              32'h42,  32'hDEAD_BEEF, 32'h0, 0);
    add(0, DM_WORD,              32'h40,  32'h0,         32'hDEAD_BEEF, 0);
    add(0, DM_WORD,              32'h200, 32'h0,         32'h0000_0055, 0);
    add(0, DM_HALFWORD,          32'h13,  32'h0,         32'h0000_1234, 0);
`endif

    foreach (tab[i]) begin
      access(0, tab[i].we, tab[i].t, tab[i].a, tab[i].wd, i % 2, $sformatf("vec%0d", i), rd, er, mrd, mer);
      chk($sformatf("vec%0d_rdata", i), rd, tab[i].er);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(tab[i].ee));
    end

    access(1, 1'b1, DM_WORD, 32'h8, 32'hCAFE_BABE, 0, "w3_store", rd, er, mrd, mer);
    access(1, 1'b0, DM_WORD, 32'h8, 32'h0, 5, "w3_hold", rd, er, mrd, mer);
    chk("w3_hold_rdata", rd, 32'hCAFE_BABE);

    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_type[1] = DM_WORD;
    req_addr[1] = 32'h40; req_wdata[1] = 32'h0000_00AA;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    model(1, 1'b1, DM_WORD, 32'h40, 32'h0000_00AA, mrd, mer);
    @(posedge clk); #1;
    rstn[1] = 1'b0;
    #1;
    chk("midrst_outs", {rsp_rdata[1][29:0], req_ready[1], rsp_valid[1]} | 32'(rsp_err[1]), 32'h0);
    @(posedge clk); #1;
    rstn[1] = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", 32'(req_ready[1]), 32'h1);
    we = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid[1]) we = 1'b1;
    end
    chk("midrst_no_rsp", 32'(we), 32'h0);
    access(1, 1'b0, DM_WORD, 32'h40, 32'h0, 0, "midrst_load", rd, er, mrd, mer);
    chk("midrst_load_rdata", rd, 32'h0000_00AA);

    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 120; k++) begin
        we = 1'($urandom);
        t  = 3'($urandom_range(0, 7));
        a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127));
        access(d, we, t, a, $urandom, $urandom_range(0, 2), "rnd", rd, er, mrd, mer);
        chk($sformatf("rnd%0d_%0d_rdata", d, k), rd, mrd);
        chk($sformatf("rnd%0d_%0d_err", d, k), 32'(er), 32'(mer));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dm_pipe.md
# dm_pipe

Parametrised, handshaked data memory for the 5-stage pipeline's MEM stage. Accepts one load/store request at a time over a valid/ready interface and applies byte/halfword/word write strobes. Performs correct sign/zero extension on loads and returns the result after a configurable number of wait states, so the pipeline can stall on memory. Optionally traps misaligned and out-of-range accesses instead of silently truncating them.

## Interface
- DEPTH_WORDS, 128: number of 32-bit words; power of two, 16..65536.
- WAIT_CYCLES, 0: extra cycles between request accept and response, 0..7.
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_type  in  3  access type (dm_pkg codes).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/halfword used for sub-word stores.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  32  load result; 0 for stores and faulted accesses.
- rsp_err  out  1  access fault; only driven high with DM_FAULT_CHECK_EN.

## Operation
- Type codes: DM_BYTE 3'b000, DM_HALFWORD 3'b001, DM_WORD 3'b010, DM_BYTE_UNSIGNED 3'b100, DM_HALFWORD_UNSIGNED 3'b101. Any other code is treated as DM_WORD.
- Word index = req_addr[ADDR_W+1:2], where ADDR_W = $clog2(DEPTH_WORDS). Byte offset = req_addr[1:0].
- Stores (write strobes):
  - DM_BYTE writes lane offset.
  - DM_HALFWORD writes lanes {offset[1],1} and {offset[1],0}.
  - DM_WORD writes all four lanes.
  - Unsigned codes on store behave as their signed counterparts.
- Loads: select the byte at offset, or the halfword at offset[1]. Signed types sign-extend from bit 7/15; unsigned types zero-extend. DM_WORD returns the word.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch the request and go to WAIT, or to RESP if WAIT_CYCLES=0.
  - WAIT: counter counts WAIT_CYCLES cycles, then go to RESP.
  - RESP: rsp_valid=1; rsp_rdata/rsp_err held stable. On rsp_ready go to IDLE.
- Store commits on the accept edge, so a later load always observes it.
- Load data is sampled from the array on the edge entering RESP.
- Memory array is not reset; it is zero-initialised at time 0 for simulation.
- Reset mid-operation: the FSM returns to IDLE and the counter clears. A store already accepted stays committed; a pending response is dropped.

## Timing
- Reset values: req_ready=0 while rstn=0, 1 from the first edge after release. rsp_valid=0, rsp_rdata=0, rsp_err=0. FSM=IDLE, counter=0.
- Accept at edge N ⇒ rsp_valid rises after edge N+1+WAIT_CYCLES. Minimum load-to-use: 1 cycle.
- req_ready is low from the accept edge until the cycle after rsp_valid&&rsp_ready. There is no back-to-back accept in the same cycle as a response handshake.
- rsp_valid stays high indefinitely until rsp_ready. The request inputs are ignored outside IDLE.

## Configuration
- DM_FAULT_CHECK_EN:
  - Defined:
    - rsp_err=1 for a misaligned halfword (offset[0]=1).
    - rsp_err=1 for a misaligned word (offset≠0).
    - rsp_err=1 for word index ≥ DEPTH_WORDS, i.e. req_addr[31:ADDR_W+2] nonzero.
    - A faulted store writes nothing; a faulted load returns 0. Latency is unchanged.
  - Undefined:
    - rsp_err tied 0.
    - Halfword uses offset[1] only; word ignores offset.
    - Upper address bits ignored, so the address wraps modulo DEPTH_WORDS*4.

## Structure
- dm_pkg: the five DM_* type codes, a dm_state_e enum (IDLE/WAIT/RESP), and a function returning the 4-bit write strobe for (type, offset).
- Sub-module dm_load_align: combinational; inputs word, type, offset; output extended 32-bit load value. Instantiated once on the RESP-path data.

## Test plan
- WAIT_CYCLES=0: store word 0x12345678 @0x10, then DM_BYTE @0x13 ⇒ 0x00000012; DM_BYTE_UNSIGNED @0x10 ⇒ 0x00000078.
- Store DM_BYTE 0xF0 @0x21, then DM_BYTE @0x21 ⇒ 0xFFFFFFF0; DM_HALFWORD @0x20 ⇒ 0xFFFFF000; DM_HALFWORD_UNSIGNED @0x20 ⇒ 0x0000F000.
- WAIT_CYCLES=3, rsp_ready held 0 for 5 cycles: rsp_valid rises exactly 4 edges after accept; data stable; req_ready stays 0 throughout.
- Assert rstn=0 during WAIT after a store 0xAA @0x40: outputs return to reset values; a later load @0x40 ⇒ 0x000000AA.
- DM_FAULT_CHECK_EN: DM_WORD store @0x42 ⇒ rsp_err=1 and the word is unchanged. Load @0x200 with DEPTH_WORDS=128 ⇒ rsp_err=1, rdata 0.
- Without the macro: load word @0x202 after storing 0x55 @0x0 ⇒ 0x00000055 (offset ignored and address wrapped).
